// File: rtl/systolic_os_array_if.sv
// Operand-stream, run-control and result-drain bundle for the output-stationary systolic array.
interface systolic_os_array_if #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_W    = 16
);
  localparam int unsigned IDX_W = $clog2(ROWS);

  logic                      start;
  logic [K_W-1:0]            k_len;
  logic                      busy;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*DATA_W-1:0]    a_col;
  logic [COLS*DATA_W-1:0]    b_row;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*ACC_W-1:0]     out_row;
  logic [IDX_W-1:0]          out_idx;
  logic                      done;

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  busy, in_ready, out_valid, out_row, out_idx, done
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output busy, in_ready, out_valid, out_row, out_idx, done
  );
endinterface

// File: rtl/systolic_os_array.sv
// Output-stationary ROWS x COLS systolic matrix engine with internal operand skew,
// bubble-tolerant operand stream, run FSM and row-serial back-pressurable result drain.
module systolic_os_array #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_W    = 16
) (
  input logic                clk,
  input logic                rst,
  systolic_os_array_if.slave bus
);
  localparam int unsigned IDX_W     = $clog2(ROWS);
  localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
  localparam int unsigned FL_W      = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t           state;
  logic [K_W-1:0]   k_lat;
  logic [K_W-1:0]   beat_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic [IDX_W-1:0] idx;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             done_q;

  logic beat;
  logic acc_clr;
  logic acc_en;

  assign beat    = bus.in_valid & in_ready_q;
  assign acc_clr = (state == IDLE) & bus.start;
  assign acc_en  = (state == FEED) | (state == FLUSH);

  // Run control; every output flag is set alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k_lat       <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      idx         <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            k_lat     <= bus.k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            idx       <= '0;
            busy_q    <= 1'b1;
            if (bus.k_len == '0) begin
              state       <= DRAIN;
              out_valid_q <= 1'b1;
            end else begin
              state      <= FEED;
              in_ready_q <= 1'b1;
            end
          end
        end
        FEED: begin
          if (beat) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (beat_cnt == k_lat - K_W'(1)) begin
              state      <= FLUSH;
              in_ready_q <= 1'b0;
              flush_cnt  <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
            state       <= DRAIN;
            out_valid_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FL_W'(1);
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (idx == IDX_W'(ROWS - 1)) begin
              idx         <= '0;
              state       <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [ROWS*DATA_W-1:0] a_sk;
  logic [ROWS-1:0]        v_sk;
  logic [COLS*DATA_W-1:0] b_sk;

  // Row r gets r delay stages; the beat-valid token rides with the A operand.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_pass
      assign a_sk[DATA_W-1:0] = bus.a_col[DATA_W-1:0];
      assign v_sk[0]          = beat;
    end else begin : g_dly
      logic [DATA_W-1:0] d [r];
      logic              v [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < r; i++) begin
            d[i] <= '0;
            v[i] <= 1'b0;
          end
        end else begin
          d[0] <= bus.a_col[r*DATA_W +: DATA_W];
          v[0] <= beat;
          for (int i = 1; i < r; i++) begin
            d[i] <= d[i-1];
            v[i] <= v[i-1];
          end
        end
      end
      assign a_sk[r*DATA_W +: DATA_W] = d[r-1];
      assign v_sk[r]                  = v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_pass
      assign b_sk[DATA_W-1:0] = bus.b_row[DATA_W-1:0];
    end else begin : g_dly
      logic [DATA_W-1:0] d [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < c; i++) d[i] <= '0;
        end else begin
          d[0] <= bus.b_row[c*DATA_W +: DATA_W];
          for (int i = 1; i < c; i++) d[i] <= d[i-1];
        end
      end
      assign b_sk[c*DATA_W +: DATA_W] = d[c-1];
    end
  end

  logic signed [DATA_W-1:0] a_q [ROWS][COLS];
  logic signed [DATA_W-1:0] b_q [ROWS][COLS];
  logic                     v_q [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc [ROWS][COLS];

  // Mesh: operands march right/down one cell per cycle; each cell accumulates its own C entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          v_q[r][c] <= 1'b0;
          acc[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        a_q[r][0] <= a_sk[r*DATA_W +: DATA_W];
        v_q[r][0] <= v_sk[r];
        for (int c = 1; c < COLS; c++) begin
          a_q[r][c] <= a_q[r][c-1];
          v_q[r][c] <= v_q[r][c-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        b_q[0][c] <= b_sk[c*DATA_W +: DATA_W];
        for (int r = 1; r < ROWS; r++) b_q[r][c] <= b_q[r-1][c];
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (acc_clr) begin
            acc[r][c] <= '0;
          end else if (acc_en && v_q[r][c]) begin
            acc[r][c] <= acc[r][c] + ACC_W'(a_q[r][c]) * ACC_W'(b_q[r][c]);
          end
        end
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign bus.out_row[c*ACC_W +: ACC_W] = acc[idx][c];
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = idx;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_os_array.sv
// Randomised scoreboard bench for systolic_os_array: matrix-product reference model,
// decoupled result monitor, directed sign/wrap, bubble, backpressure, k=0 and reset cases.
module tb_systolic_os_array;
  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned K_W    = 16;
  localparam int unsigned IDX_W  = $clog2(ROWS);
  localparam int unsigned ROW_W  = COLS * ACC_W;
  localparam int          MAXK   = 16;

  typedef struct {
    int               idx;
    logic [ROW_W-1:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_os_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) ifc ();

  systolic_os_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   a_m [ROWS][MAXK];
  int   b_m [MAXK][COLS];

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // C = A x B with plain integer sums, truncated to the accumulator width.
  task automatic push_expected(input int k);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.idx = r;
      e.row = '0;
      for (int c = 0; c < COLS; c++) begin
        longint s = 0;
        for (int j = 0; j < k; j++) s += longint'(a_m[r][j]) * longint'(b_m[j][c]);
        e.row[c*ACC_W +: ACC_W] = ACC_W'(s);
      end
      sb.push_back(e);
    end
  endtask

  function automatic int rnd16();
    logic [DATA_W-1:0] t;
    t = DATA_W'($urandom);
    return int'($signed(t));
  endfunction

  task automatic fill_const(input int av, input int bv);
    for (int j = 0; j < MAXK; j++) begin
      for (int r = 0; r < ROWS; r++) a_m[r][j] = av;
      for (int c = 0; c < COLS; c++) b_m[j][c] = bv;
    end
  endtask

  task automatic fill_rand();
    for (int j = 0; j < MAXK; j++) begin
      for (int r = 0; r < ROWS; r++) a_m[r][j] = rnd16();
      for (int c = 0; c < COLS; c++) b_m[j][c] = rnd16();
    end
  endtask

  task automatic fill_ident();
    for (int j = 0; j < MAXK; j++) begin
      for (int r = 0; r < ROWS; r++) a_m[r][j] = (r == j) ? 1 : 0;
      for (int c = 0; c < COLS; c++) b_m[j][c] = 8 * j + c;
    end
  endtask

  // bub_pct < 0 means in_valid low on alternate cycles.
  task automatic run(input int k, input int bub_pct, input int bp_pct, input bit stall3, input bit poke);
    int cyc, bi, last_beat, stall_n;
    bit seen_ov, acc_now;
    push_expected(k);
    ifc.start     = 1'b1;
    ifc.k_len     = K_W'(k);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("busy_in_run", ifc.busy, 1);
    cyc = 1; bi = 0; last_beat = 0; stall_n = 0; seen_ov = 0;
    while (cyc < 4000 && !ifc.done) begin
      if (ifc.out_valid && !seen_ov) begin
        seen_ov = 1;
        chk("first_valid_latency", cyc, (k == 0) ? 1 : last_beat + ROWS + COLS);
      end
      if (bub_pct < 0) ifc.in_valid = (bi < k) && (cyc % 2 == 1);
      else             ifc.in_valid = (bi < k) && (int'($urandom_range(99)) >= bub_pct);
      for (int r = 0; r < ROWS; r++)
        ifc.a_col[r*DATA_W +: DATA_W] = ifc.in_valid ? DATA_W'(a_m[r][bi]) : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++)
        ifc.b_row[c*DATA_W +: DATA_W] = ifc.in_valid ? DATA_W'(b_m[bi][c]) : DATA_W'($urandom);
      ifc.start = poke && (bi == 1) && ifc.in_ready;
      ifc.k_len = ifc.start ? K_W'(1) : K_W'(k);
      if (stall3 && ifc.out_valid && ifc.out_idx == IDX_W'(3) && stall_n < 5) begin
        ifc.out_ready = 1'b0;
        stall_n++;
      end else begin
        ifc.out_ready = int'($urandom_range(99)) >= bp_pct;
      end
      acc_now = ifc.in_valid && ifc.in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        last_beat = cyc;
        bi++;
      end
      cyc++;
    end
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
    if (!ifc.done) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: got no done after %0d cycles, k=%0d", cyc, k);
    end else begin
      chk("busy_at_done", ifc.busy, 0);
      chk("in_ready_at_done", ifc.in_ready, 0);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted row; also checks drain hold and done pulse.
  bit               hold_pend = 0;
  bit               done_pend = 0;
  logic [IDX_W-1:0] h_idx;
  logic [ROW_W-1:0] h_row;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
      done_pend = 0;
    end else begin
      if (done_pend || ifc.done) chk("done_pulse", ifc.done, done_pend);
      done_pend = 0;
      if (hold_pend) begin
        chk("hold_idx", ifc.out_idx, h_idx);
        chk("hold_row", ifc.out_row, h_row);
      end
      hold_pend = ifc.out_valid && !ifc.out_ready;
      h_idx = ifc.out_idx;
      h_row = ifc.out_row;
      if (ifc.out_valid && ifc.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_row: got idx %0d with empty scoreboard", ifc.out_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("row_idx", ifc.out_idx, e.idx);
          chk("row_data", ifc.out_row, e.row);
          done_pend = (e.idx == ROWS - 1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0; ifc.k_len = '0; ifc.in_valid = 1'b0;
    ifc.a_col = '0;   ifc.b_row = '0; ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_out_idx", ifc.out_idx, 0);
    chk("rst_out_row", ifc.out_row, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_ident();
    run(8, 0, 0, 0, 0);
    run(8, -1, 0, 0, 0);

    fill_const(-32768, -32768);
    run(1, 0, 0, 0, 0);
    run(4, 0, 0, 0, 0);
    fill_const(-1, 3);
    run(2, 0, 0, 0, 0);

    fill_rand();
    run(8, 0, 0, 1, 0);

    run(0, 0, 0, 0, 0);
    fill_const(1, 1);
    run(1, 0, 0, 0, 0);

    // Abort a run mid-FEED; outputs drop with the asynchronous reset.
    fill_rand();
    ifc.start = 1'b1; ifc.k_len = K_W'(8);
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_in_ready", ifc.in_ready, 0);
    chk("mid_rst_out_valid", ifc.out_valid, 0);
    chk("mid_rst_done", ifc.done, 0);
    chk("mid_rst_out_idx", ifc.out_idx, 0);
    chk("mid_rst_out_row", ifc.out_row, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_const(2, 2);
    run(1, 0, 0, 0, 0);

    fill_rand();
    run(6, 20, 0, 0, 1);

    for (int i = 0; i < 12; i++) begin
      fill_rand();
      run(int'($urandom_range(MAXK, 1)), 30, 30, 0, (i % 3) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
